// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped LED, debounced switch and timer peripheral.
// Decoded alongside dmem; o_hit steers o_rdata into the load path.
module mmio_io_ctrl #(
    parameter int             N         = 64,
    parameter logic [N-1:0]   BASE      = 'h8000,
    parameter int             NLED      = 16,
    parameter int             NSW       = 16,
    parameter int             DB_CYCLES = 4,
    parameter int             PRESCALE  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    i_addr,
    input  logic [N-1:0]    i_wdata,
    input  logic            i_we,
    input  logic            i_re,
    output logic [N-1:0]    o_rdata,
    output logic            o_hit,
    input  logic [NSW-1:0]  i_sw,
    output logic [NLED-1:0] o_led,
    output logic            o_irq
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PCW = $clog2(PRESCALE + 1);

    logic [2:0]      off;
    logic            wr;
    logic            wr_led;
    logic            wr_edge;
    logic            wr_timer;
    logic            wr_tcmp;
    logic            wr_ctrl;

    logic [NSW-1:0]  sync1;
    logic [NSW-1:0]  sync2;
    logic [NSW-1:0]  cand;
    logic [NSW-1:0]  sw;
    logic [NSW-1:0]  sw_edge;
    logic [DBW-1:0]  dbc;
    logic            accept;
    logic [NSW-1:0]  edge_set;
    logic [NSW-1:0]  edge_clr;

    logic [NLED-1:0] led;
    logic [31:0]     timer;
    logic [31:0]     tcmp;
    logic [31:0]     nxt;
    logic [PCW-1:0]  pc;
    logic            ten;
    logic            tclr;
    logic            tmatch;
    logic            tick;
    logic            tm_set;
    logic [31:0]     rd32;
    logic            unused_wdata;

    assign off   = i_addr[5:3];
    assign o_hit = (i_addr[N-1:6] == BASE[N-1:6])
                && (i_addr[2:0] == 3'd0)
                && (off <= 3'd5);

    assign wr       = i_we & o_hit;
    assign wr_led   = wr && (off == 3'd0);
    assign wr_edge  = wr && (off == 3'd2);
    assign wr_timer = wr && (off == 3'd3);
    assign wr_tcmp  = wr && (off == 3'd4);
    assign wr_ctrl  = wr && (off == 3'd5);

    assign unused_wdata = ^i_wdata;

    assign accept   = (sync2 == cand)
                   && (dbc == DBW'(DB_CYCLES - 1))
                   && (cand != sw);
    assign edge_set = accept ? (cand ^ sw) : '0;
    assign edge_clr = wr_edge ? i_wdata[NSW-1:0] : '0;

    assign tick   = ten && (pc == PCW'(PRESCALE - 1));
    assign nxt    = timer + 32'd1;
    assign tm_set = tick && !wr_timer && (nxt == tcmp);

    assign o_led = led;
    assign o_irq = tmatch | (|sw_edge);

    // LED output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) led <= '0;
        else if (wr_led) led <= i_wdata[NLED-1:0];
    end

    // Switch synchroniser, debounce candidate and accepted value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            dbc   <= '0;
            sw    <= '0;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                dbc  <= '0;
            end else if (accept) begin
                sw <= cand;
            end else if (dbc != DBW'(DB_CYCLES - 1)) begin
                dbc <= dbc + 1'b1;
            end
        end
    end

    // Sticky change flags; a hardware set outranks a W1C
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sw_edge <= '0;
        else sw_edge <= (sw_edge & ~edge_clr) | edge_set;
    end

    // Prescaler, timer count, compare and control bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            timer  <= '0;
            tcmp   <= '1;
            ten    <= 1'b0;
            tclr   <= 1'b0;
            tmatch <= 1'b0;
        end else begin
            if (ten) pc <= tick ? '0 : pc + 1'b1;
            if (wr_timer) timer <= i_wdata[31:0];
            else if (tick) timer <= (tm_set && tclr) ? '0 : nxt;
            if (wr_tcmp) tcmp <= i_wdata[31:0];
            if (wr_ctrl) begin
                ten  <= i_wdata[0];
                tclr <= i_wdata[2];
            end
            tmatch <= (tmatch & ~(wr_ctrl & i_wdata[1])) | tm_set;
        end
    end

    // Read mux, zero-extended to the port width
    always_comb begin
        rd32 = '0;
        case (off)
            3'd0:    rd32 = 32'(led);
            3'd1:    rd32 = 32'(sw);
            3'd2:    rd32 = 32'(sw_edge);
            3'd3:    rd32 = timer;
            3'd4:    rd32 = tcmp;
            3'd5:    rd32 = {29'd0, tclr, tmatch, ten};
            default: rd32 = '0;
        endcase
    end

    assign o_rdata = (o_hit && i_re) ? N'(rd32) : '0;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed and random checks of mmio_io_ctrl
// against a register-level reference model.
module tb_mmio_io_ctrl;

    localparam int          N    = 64;
    localparam logic [63:0] BASE = 64'h8000;
    localparam int          NLED = 16;
    localparam int          NSW  = 16;
    localparam int          DB   = 4;
    localparam int          PS   = 1;

    logic            clk;
    logic            reset;
    logic [N-1:0]    i_addr;
    logic [N-1:0]    i_wdata;
    logic            i_we;
    logic            i_re;
    logic [N-1:0]    o_rdata;
    logic            o_hit;
    logic [NSW-1:0]  i_sw;
    logic [NLED-1:0] o_led;
    logic            o_irq;

    int n_tests;
    int n_fail;

    logic [NLED-1:0] m_led;
    logic [NSW-1:0]  m_sw;
    logic [NSW-1:0]  m_edge;
    logic [31:0]     m_timer;
    logic [31:0]     m_tcmp;
    logic            m_ten;
    logic            m_tclr;
    logic            m_tmatch;
    int              m_en;
    logic [NSW-1:0]  hist[$];

    logic [63:0]     pre_rd;
    logic            pre_hit;
    logic [15:0]     cur_sw;

    mmio_io_ctrl #(
        .N(N), .BASE(BASE), .NLED(NLED), .NSW(NSW),
        .DB_CYCLES(DB), .PRESCALE(PS)
    ) dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_we(i_we), .i_re(i_re),
        .o_rdata(o_rdata), .o_hit(o_hit),
        .i_sw(i_sw), .o_led(o_led), .o_irq(o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [63:0] a);
        return (a[63:6] == BASE[63:6]) && (a[2:0] == 3'd0)
            && (a[5:3] <= 3'd5);
    endfunction

    function automatic logic [63:0] m_rd(input logic [63:0] a,
                                         input logic re);
        logic [63:0] v;
        v = 64'd0;
        if (m_hit(a) && re) begin
            case (a[5:3])
                3'd0: v = 64'(m_led);
                3'd1: v = 64'(m_sw);
                3'd2: v = 64'(m_edge);
                3'd3: v = 64'(m_timer);
                3'd4: v = 64'(m_tcmp);
                3'd5: v = {61'd0, m_tclr, m_tmatch, m_ten};
                default: v = 64'd0;
            endcase
        end
        return v;
    endfunction

    function automatic logic m_irq();
        return m_tmatch | (|m_edge);
    endfunction

    task automatic model_reset();
        m_led    = '0;
        m_sw     = '0;
        m_edge   = '0;
        m_timer  = '0;
        m_tcmp   = 32'hFFFF_FFFF;
        m_ten    = 1'b0;
        m_tclr   = 1'b0;
        m_tmatch = 1'b0;
        m_en     = 0;
        hist.delete();
        for (int i = 0; i < DB + 3; i++) hist.push_back('0);
    endtask

    // Accepted value = a switch vector seen unchanged for DB+1
    // consecutive samples, ending two samples back (synchroniser).
    task automatic model_step(input logic [63:0] a,
                              input logic [63:0] wd,
                              input logic we,
                              input logic [NSW-1:0] sw);
        logic [2:0]     off;
        logic           wr;
        logic           stable;
        logic [NSW-1:0] set_e;
        logic [NSW-1:0] clr_e;
        logic           tick;
        logic           mset;
        logic [31:0]    nx;
        off = a[5:3];
        wr  = we && m_hit(a);
        hist.push_back(sw);
        void'(hist.pop_front());
        stable = 1'b1;
        for (int i = 1; i <= DB; i++)
            if (hist[i] != hist[0]) stable = 1'b0;
        set_e = stable ? (hist[0] ^ m_sw) : '0;
        clr_e = (wr && off == 3'd2) ? wd[NSW-1:0] : '0;
        tick  = m_ten && (((m_en + 1) % PS) == 0);
        if (m_ten) m_en++;
        mset = 1'b0;
        if (wr && off == 3'd3) begin
            m_timer = wd[31:0];
        end else if (tick) begin
            nx = m_timer + 32'd1;
            if (nx == m_tcmp) begin
                mset = 1'b1;
                m_timer = m_tclr ? 32'd0 : nx;
            end else begin
                m_timer = nx;
            end
        end
        if (wr && off == 3'd5 && wd[1]) m_tmatch = 1'b0;
        if (mset) m_tmatch = 1'b1;
        if (stable) m_sw = hist[0];
        m_edge = (m_edge & ~clr_e) | set_e;
        if (wr && off == 3'd0) m_led = wd[NLED-1:0];
        if (wr && off == 3'd4) m_tcmp = wd[31:0];
        if (wr && off == 3'd5) begin
            m_ten  = wd[0];
            m_tclr = wd[2];
        end
    endtask

    task automatic cyc(input logic [63:0] a,
                       input logic [63:0] wd,
                       input logic we,
                       input logic re,
                       input logic [15:0] sw);
        i_addr  = a;
        i_wdata = wd;
        i_we    = we;
        i_re    = re;
        i_sw    = sw;
        #1;
        pre_rd  = o_rdata;
        pre_hit = o_hit;
        check("hit", 64'(o_hit), 64'(m_hit(a)));
        check("rdata", o_rdata, m_rd(a, re));
        @(posedge clk);
        model_step(a, wd, we, sw);
        #1;
        check("led", 64'(o_led), 64'(m_led));
        check("irq", 64'(o_irq), 64'(m_irq()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_led", 64'(o_led), 64'd0);
        check("rst_irq", 64'(o_irq), 64'd0);
        i_we = 1'b0;
        i_re = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_addr = BASE + 64'(8 * k);
            #1;
            check("rst_reg", o_rdata, m_rd(i_addr, 1'b1));
        end
        i_addr = BASE + 64'd32;
        #1;
        check("rst_tcmp", o_rdata, 64'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [63:0] rnd_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 8) return BASE + 64'(8 * k);
        if (k == 8)
            return BASE + 64'(8 * $urandom_range(0, 7))
                 + 64'($urandom_range(1, 7));
        return 64'h4000 + 64'(8 * $urandom_range(0, 7));
    endfunction

    task automatic rnd_run(input int cycles);
        logic [63:0] a;
        logic [63:0] wd;
        for (int i = 0; i < cycles; i++) begin
            a  = rnd_addr();
            wd = {$urandom, $urandom};
            if (a[5:3] == 3'd4)
                wd[31:0] = 32'($urandom_range(0, 30));
            if (a[5:3] == 3'd3 && $urandom_range(0, 1) == 1)
                wd[31:0] = 32'hFFFF_FFF0
                         + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                cur_sw = 16'($urandom_range(0, 7));
            cyc(a, wd, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, cur_sw);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cur_sw  = '0;
        reset   = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
        i_we    = 1'b0;
        i_re    = 1'b0;
        i_sw    = '0;
        model_reset();
        #12;
        check("por_led", 64'(o_led), 64'd0);
        check("por_irq", 64'(o_irq), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        cyc(BASE, 64'hA5A5, 1'b1, 1'b0, 16'd0);
        check("led_a5", 64'(o_led), 64'hA5A5);
        cyc(BASE, 64'd0, 1'b0, 1'b1, 16'd0);
        check("led_rd", pre_rd, 64'hA5A5);
        cyc(BASE + 64'd48, 64'd0, 1'b0, 1'b1, 16'd0);
        check("off6_hit", 64'(pre_hit), 64'd0);

        for (int i = 0; i < 10; i++) begin
            cyc(BASE + 64'd8, 64'd0, 1'b0, 1'b1, 16'h3);
            check("sw_step", pre_rd, (i >= 7) ? 64'h3 : 64'h0);
        end
        cyc(BASE + 64'd16, 64'd0, 1'b0, 1'b1, 16'h3);
        check("sw_edge", pre_rd, 64'h3);
        check("sw_irq", 64'(o_irq), 64'd1);
        cyc(BASE + 64'd16, 64'h1, 1'b1, 1'b0, 16'h3);
        cyc(BASE + 64'd16, 64'd0, 1'b0, 1'b1, 16'h3);
        check("sw_w1c", pre_rd, 64'h2);
        cyc(BASE + 64'd8, 64'd0, 1'b0, 1'b1, 16'h0);
        cyc(BASE + 64'd8, 64'd0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 12; i++)
            cyc(BASE + 64'd8, 64'd0, 1'b0, 1'b1, 16'h3);
        check("glitch_sw", pre_rd, 64'h3);
        cyc(BASE + 64'd16, 64'd0, 1'b0, 1'b1, 16'h3);
        check("glitch_edge", pre_rd, 64'h2);

        do_reset();
        cyc(BASE + 64'd32, 64'd5, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd40, 64'd5, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(BASE + 64'd24, 64'd0, 1'b0, 1'b1, 16'd0);
            check("tmr_seq", pre_rd, 64'(i % 5));
        end
        check("tmr_irq", 64'(o_irq), 64'd1);

        cyc(BASE + 64'd40, 64'd2, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd32, 64'd0, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd24, 64'hFFFF_FFFF, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd40, 64'd1, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd40, 64'd3, 1'b1, 1'b0, 16'd0);
        cyc(BASE + 64'd24, 64'd0, 1'b0, 1'b1, 16'd0);
        check("wrap_tmr", pre_rd, 64'd0);
        cyc(BASE + 64'd40, 64'd0, 1'b0, 1'b1, 16'd0);
        check("wrap_ctrl", pre_rd, 64'd3);

        cur_sw = '0;
        rnd_run(2000);
        do_reset();
        rnd_run(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
